// File: rtl/pipe_defs_pkg.sv
// pipe_defs: definitions shared by the pipeline stages and the memory arbiter.
//   PIPE_ADDR_W / PIPE_DATA_W : default address / data widths
//   arb_state_t               : arbiter FSM state encoding (2 bits)
//   arb_owner_t               : which requester owns the current access
package pipe_defs;

  localparam int PIPE_ADDR_W = 32;
  localparam int PIPE_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_IF = 2'd1,
    ST_ACC_DM = 2'd2,
    ST_DONE   = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates the single-ported unified memory between instruction
// fetch (IF) and the data-memory stage (DM). One access at a time, each held for
// LATENCY cycles, followed by a one-cycle ready pulse and one bubble cycle.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   if_req/if_addr/if_flush  fetch request, PC, branch-redirect flush
//   if_ready/if_rdata        fetch completion pulse and instruction
//   if_stall                 freezes PC and IF/ID while a fetch is pending
//   dm_req/dm_we/dm_addr/dm_wdata  data request (load or store)
//   dm_ready/dm_rdata        data completion pulse and load data
//   dm_stall                 freezes the whole pipeline while data is pending
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata  memory-side interface
module mem_arbiter
  import pipe_defs::*;
#(
  parameter int ADDR_W     = PIPE_ADDR_W,
  parameter int DATA_W     = PIPE_DATA_W,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LATENCY - 1);
  localparam logic [SC_W-1:0]  STARVE_FULL = SC_W'(STARVE_MAX);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  arb_owner_t        r_owner;
  logic [CNT_W-1:0]  r_cnt;
  logic [SC_W-1:0]   r_starve_cnt;
  logic              r_flush_pend;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  // DM normally wins; once fetch has been passed over STARVE_MAX times it is forced.
  logic w_force_if;
  logic w_grant_dm;
  logic w_grant_if;
  logic w_acc_last;
  logic w_if_drop;

  assign w_force_if = if_req & (r_starve_cnt == STARVE_FULL);
  assign w_grant_dm = dm_req & ~w_force_if;
  assign w_grant_if = if_req & ~w_grant_dm;
  assign w_acc_last = (r_cnt == '0);
  // A redirect seen at any point of the fetch (or live in the ready cycle)
  // turns the fetched word into garbage for the pipeline.
  assign w_if_drop  = r_flush_pend | if_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_dm) begin
          w_state_next = ST_ACC_DM;
        end else if (w_grant_if) begin
          w_state_next = ST_ACC_IF;
        end
      end
      ST_ACC_IF, ST_ACC_DM: begin
        if (w_acc_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= OWN_IF;
      r_cnt        <= '0;
      r_starve_cnt <= '0;
      r_flush_pend <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_flush_pend <= 1'b0;
          if (w_grant_dm) begin
            r_owner     <= OWN_DM;
            r_mem_en    <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_cnt       <= CNT_LOAD;
            if (if_req && (r_starve_cnt != STARVE_FULL)) begin
              r_starve_cnt <= r_starve_cnt + 1'b1;
            end
          end else if (w_grant_if) begin
            r_owner      <= OWN_IF;
            r_mem_en     <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= if_addr;
            r_mem_wdata  <= '0;
            r_cnt        <= CNT_LOAD;
            r_starve_cnt <= '0;
          end
        end
        ST_ACC_IF, ST_ACC_DM: begin
          if (r_state == ST_ACC_IF && if_flush) begin
            r_flush_pend <= 1'b1;
          end
          if (w_acc_last) begin
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            if (r_state == ST_ACC_IF) begin
              if (!w_if_drop) begin
                r_if_rdata <= mem_rdata;
              end
            end else if (!r_mem_we) begin
              r_dm_rdata <= mem_rdata;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: r_flush_pend <= 1'b0;
        default: r_flush_pend <= 1'b0;
      endcase
    end
  end

  assign if_ready  = (r_state == ST_DONE) && (r_owner == OWN_IF) && !w_if_drop;
  assign dm_ready  = (r_state == ST_DONE) && (r_owner == OWN_DM);
  assign if_stall  = if_req & ~if_ready;
  assign dm_stall  = dm_req & ~dm_ready;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import pipe_defs::*;

  localparam int LAT = 2;
  localparam int SMAX = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_flush = 1'b0;
  logic        if_ready;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_ready;
  logic [31:0] dm_rdata;
  logic        dm_stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ready(if_ready), .if_rdata(if_rdata), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write on the clock while enabled.
  logic [31:0] mem_arr [0:255];
  assign mem_rdata = mem_arr[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t if_q[$];
  exp_t dm_q[$];

  // Scoreboard: every ready pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (if_ready) begin
        total++;
        if (if_q.size() == 0) begin
          bad++;
          $display("FAIL if_ready_unexpected: got ready at cycle %0d want none", cyc);
        end else begin
          e = if_q.pop_front();
          if (if_rdata !== e.data || cyc != e.cyc) begin
            bad++;
            $display("FAIL if_ready: got data %h cycle %0d want data %h cycle %0d", if_rdata, cyc, e.data, e.cyc);
          end
        end
      end
      if (dm_ready) begin
        total++;
        if (dm_q.size() == 0) begin
          bad++;
          $display("FAIL dm_ready_unexpected: got ready at cycle %0d want none", cyc);
        end else begin
          e = dm_q.pop_front();
          if (dm_rdata !== e.data || cyc != e.cyc) begin
            bad++;
            $display("FAIL dm_ready: got data %h cycle %0d want data %h cycle %0d", dm_rdata, cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
        if_rdata !== 32'h0 || dm_rdata !== 32'h0 || dut.r_state !== ST_IDLE) begin
      bad++;
      $display("FAIL reset_state: got en=%b we=%b addr=%h rdata=%h/%h state=%0d want all zero",
               mem_en, mem_we, mem_addr, if_rdata, dm_rdata, dut.r_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset: outputs idle");
  endtask

  task automatic test_fetch();
    int t0;
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        t0 = cyc;
        if_addr = 32'h8;
        if_req = 1'b1;
        if_q.push_back('{32'h8C220004, t0 + LAT + 1});
      end
      @(negedge clk);
      total++;
      if (if_stall !== (c <= LAT)) begin
        bad++;
        $display("FAIL fetch_stall: cycle %0d got %b want %b", c, if_stall, (c <= LAT));
      end
      total++;
      if (mem_en !== (c >= 1 && c <= LAT) || (mem_en && mem_addr !== 32'h8)) begin
        bad++;
        $display("FAIL fetch_mem_en: cycle %0d got en=%b addr=%h want en=%b addr=8", c, mem_en, mem_addr, (c >= 1 && c <= LAT));
      end
      if (if_ready) if_req = 1'b0;
    end
    $display("fetch: addr 0x8 -> 0x8C220004");
  endtask

  task automatic test_both_req();
    int t0;
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        t0 = cyc;
        if_addr = 32'h8; if_req = 1'b1;
        dm_addr = 32'h40; dm_we = 1'b0; dm_req = 1'b1;
        dm_q.push_back('{32'h1234, t0 + 3});
        if_q.push_back('{32'h8C220004, t0 + 7});
      end
      @(negedge clk);
      if (c == 1) begin
        total++;
        if (mem_addr !== 32'h40) begin
          bad++;
          $display("FAIL both_first_grant: got addr %h want 00000040", mem_addr);
        end
      end
      if (c == 5) begin
        total++;
        if (!mem_en || mem_addr !== 32'h8) begin
          bad++;
          $display("FAIL both_second_grant: got en=%b addr=%h want en=1 addr=00000008", mem_en, mem_addr);
        end
      end
      if (dm_ready) dm_req = 1'b0;
      if (if_ready) if_req = 1'b0;
    end
    $display("both_req: DM then IF");
  endtask

  task automatic test_starvation();
    int t0;
    logic [31:0] want_addr;
    for (int c = 0; c <= 12; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        t0 = cyc;
        if_addr = 32'h8; if_req = 1'b1;
        dm_addr = 32'h40; dm_we = 1'b0; dm_req = 1'b1;
        dm_q.push_back('{32'h1234, t0 + 3});
        dm_q.push_back('{32'h1234, t0 + 7});
        if_q.push_back('{32'h8C220004, t0 + 11});
      end
      @(negedge clk);
      if (c == 1 || c == 5 || c == 9) begin
        want_addr = (c == 9) ? 32'h8 : 32'h40;
        total++;
        if (mem_addr !== want_addr) begin
          bad++;
          $display("FAIL starve_grant: cycle %0d got addr %h want %h", c, mem_addr, want_addr);
        end
      end
      if (c == 8) begin
        total++;
        if (dut.r_starve_cnt !== 2'(SMAX)) begin
          bad++;
          $display("FAIL starve_cnt_full: got %0d want %0d", dut.r_starve_cnt, SMAX);
        end
      end
      if (c == 9) begin
        total++;
        if (dut.r_starve_cnt !== 2'd0) begin
          bad++;
          $display("FAIL starve_cnt_clear: got %0d want 0", dut.r_starve_cnt);
        end
      end
      if (if_ready) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end
    $display("starvation: DM, DM, IF");
  endtask

  task automatic test_flush();
    int t0;
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        if_addr = 32'h10; if_req = 1'b1;
      end
      if (c == 2) if_flush = 1'b1;
      if (c == 3) begin
        if_flush = 1'b0;
        if_req = 1'b0;
      end
      @(negedge clk);
      if (c == 4) begin
        total++;
        if (dut.r_state !== ST_IDLE || if_rdata !== 32'h8C220004) begin
          bad++;
          $display("FAIL flush_drop: got state=%0d rdata=%h want state=0 rdata=8c220004", dut.r_state, if_rdata);
        end
      end
    end
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        t0 = cyc;
        if_addr = 32'h20; if_req = 1'b1;
        if_q.push_back('{32'hA5A50020, t0 + LAT + 1});
      end
      @(negedge clk);
      if (if_ready) if_req = 1'b0;
    end
    $display("flush: fetch 0x10 dropped, fetch 0x20 done");
  endtask

  task automatic test_store();
    int t0;
    for (int c = 0; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        t0 = cyc;
        dm_addr = 32'h44; dm_wdata = 32'hDEADBEEF; dm_we = 1'b1; dm_req = 1'b1;
        dm_q.push_back('{32'h1234, t0 + LAT + 1});
      end
      if (c == 1) begin
        dm_wdata = 32'h0BADF00D;
        dm_addr = 32'h48;
      end
      @(negedge clk);
      total++;
      if (mem_we !== (c >= 1 && c <= LAT) || (mem_we && (mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h44))) begin
        bad++;
        $display("FAIL store_we: cycle %0d got we=%b addr=%h wdata=%h want we=%b addr=44 wdata=deadbeef",
                 c, mem_we, mem_addr, mem_wdata, (c >= 1 && c <= LAT));
      end
      if (dm_ready) begin
        dm_req = 1'b0;
        dm_we = 1'b0;
      end
    end
    total++;
    if (mem_arr[17] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL store_mem: got %h want deadbeef", mem_arr[17]);
    end
    $display("store: 0xDEADBEEF -> 0x44");
  endtask

  task automatic test_reset_mid();
    int t0;
    for (int c = 0; c <= 8; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        t0 = cyc;
        dm_addr = 32'h40; dm_we = 1'b0; dm_req = 1'b1;
      end
      if (c == 2) rst = 1'b1;
      if (c == 3) begin
        rst = 1'b0;
        dm_q.push_back('{32'h1234, t0 + 3 + LAT + 1});
      end
      @(negedge clk);
      if (c == 3) begin
        total++;
        if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 ||
            if_rdata !== 32'h0 || dm_rdata !== 32'h0 || dut.r_state !== ST_IDLE) begin
          bad++;
          $display("FAIL reset_mid: got en=%b we=%b rdy=%b/%b addr=%h rdata=%h/%h state=%0d want all zero",
                   mem_en, mem_we, if_ready, dm_ready, mem_addr, if_rdata, dm_rdata, dut.r_state);
        end
      end
      if (dm_ready) dm_req = 1'b0;
    end
    $display("reset_mid: access abandoned, reissue done");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] <= 32'h0;
    mem_arr[2]  <= 32'h8C220004;
    mem_arr[4]  <= 32'h13579BDF;
    mem_arr[8]  <= 32'hA5A50020;
    mem_arr[16] <= 32'h00001234;
    test_reset();
    test_fetch();
    test_both_req();
    test_starvation();
    test_flush();
    test_store();
    test_reset_mid();
    repeat (2) @(posedge clk);
    total++;
    if (if_q.size() != 0 || dm_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d/%0d pending want 0/0", if_q.size(), dm_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
